// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared types and constants for the mux selector sequencer
// Contents: debounce state enum, step direction constants, selector width.
package mux_seq_pkg;

  localparam int SEL_W = 2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    REL,        // stable released
    PRESS_CNT,  // candidate press, counting stable samples
    PRS,        // stable pressed
    REL_CNT     // candidate release, counting stable samples
  } deb_state_e;

endpackage

// File: rtl/mux_select_sequencer_key_debouncer.sv
// rtl/mux_select_sequencer_key_debouncer.sv - key synchroniser, debounce FSM and step pulse
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-high reset
//   key_n in  raw asynchronous push-button, active-low
//   step  out one-cycle pulse in the cycle a press is accepted (no pulse on release)
module key_debouncer
  import mux_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic step
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       key_s;
  deb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  assign key_s   = sync2_q;
  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= REL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sample that moves REL/PRS into a counting state is the first of the
  // DEBOUNCE_CYCLES stable samples, so acceptance is checked on the
  // incremented count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    case (state_q)
      REL: begin
        if (!key_s) begin
          state_d = PRESS_CNT;
          cnt_d   = '0;
        end
      end
      PRESS_CNT: begin
        if (key_s) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = PRS;
          cnt_d   = '0;
          step    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRS: begin
        if (key_s) begin
          state_d = REL_CNT;
          cnt_d   = '0;
        end
      end
      REL_CNT: begin
        if (!key_s) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - push-button driven 2-bit mux selector with optional auto-scan
// Optional feature macro: SEL_AUTOSCAN_EN (adds auto_en port, SCAN_CYCLES, scan counter).
// Ports:
//   clk       in  system clock, rising edge
//   rst       in  synchronous active-high reset
//   key_n     in  raw push-button, active-low
//   dir       in  0 = increment, 1 = decrement, sampled when a step is applied
//   auto_en   in  auto-scan enable level (SEL_AUTOSCAN_EN only)
//   s         out registered selector
//   s_onehot  out registered 1 << s
//   s_changed out one-cycle pulse in the first cycle s holds a new value
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef SEL_AUTOSCAN_EN
  ,
  parameter int SCAN_CYCLES = 50_000_000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n,
  input  logic             dir,
`ifdef SEL_AUTOSCAN_EN
  input  logic             auto_en,
`endif
  output logic [SEL_W-1:0] s,
  output logic [3:0]       s_onehot,
  output logic             s_changed
);

  logic             key_step;
  logic             step;
  logic [SEL_W-1:0] s_q, s_d;
  logic [3:0]       s_onehot_q;
  logic             s_changed_q;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_n),
    .step (key_step)
  );

`ifdef SEL_AUTOSCAN_EN
  localparam int SW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          scan_step;

  // A scan step always restarts the counter, so a coincident key step is
  // simply merged into the same single step.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    scan_step  = 1'b0;
    if (!auto_en) begin
      scan_cnt_d = '0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_step  = 1'b1;
    end else begin
      scan_cnt_d = scan_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign step = key_step | scan_step;
`else
  assign step = key_step;
`endif

  always_comb begin
    s_d = s_q;
    if (step) begin
      s_d = (dir == DIR_DOWN) ? (s_q - SEL_W'(1)) : (s_q + SEL_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      s_onehot_q  <= 4'b0001;
      s_changed_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      s_onehot_q  <= 4'b0001 << s_d;
      s_changed_q <= step;
    end
  end

  assign s         = s_q;
  assign s_onehot  = s_onehot_q;
  assign s_changed = s_changed_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - self-checking bench for mux_select_sequencer
module tb_mux_select_sequencer;

  localparam int D = 4;
`ifdef SEL_AUTOSCAN_EN
  localparam int SC = 10;
  logic auto_en = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic       dir = 1'b0;
  logic [1:0] s;
  logic [3:0] s_onehot;
  logic       s_changed;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // behavioural model state
  int   m_s = 0;
  logic m_chg = 1'b0;
  logic m_p1 = 1'b1;
  logic m_p2 = 1'b1;
  logic m_stable = 1'b1;
  int   m_run = 0;
  int   m_sc = 0;
  bit   m_valid = 1'b0;

  // observed change events
  int chg_t[$];
  int chg_v[$];
  int change_cnt = 0;
  int last_change = 0;

  mux_select_sequencer #(
    .DEBOUNCE_CYCLES(D)
`ifdef SEL_AUTOSCAN_EN
    ,
    .SCAN_CYCLES(SC)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .dir      (dir),
`ifdef SEL_AUTOSCAN_EN
    .auto_en  (auto_en),
`endif
    .s        (s),
    .s_onehot (s_onehot),
    .s_changed(s_changed)
  );

  always #5 clk = ~clk;

  // Model: pin seen by the debouncer two samples late; a press/release is
  // accepted once D consecutive samples disagree with the stable level.
  always @(posedge clk) begin
    logic ks;
    bit   kstep;
    bit   sstep;
    cyc = cyc + 1;
    if (rst) begin
      m_s = 0; m_chg = 1'b0; m_p1 = 1'b1; m_p2 = 1'b1;
      m_stable = 1'b1; m_run = 0; m_sc = 0;
    end else begin
      ks = m_p2;
      m_p2 = m_p1;
      m_p1 = key_n;
      kstep = 1'b0;
      sstep = 1'b0;
      if (ks != m_stable) begin
        m_run = m_run + 1;
        if (m_run == D) begin
          m_stable = ks;
          m_run = 0;
          kstep = (ks == 1'b0);
        end
      end else begin
        m_run = 0;
      end
`ifdef SEL_AUTOSCAN_EN
      if (!auto_en) m_sc = 0;
      else if (m_sc == SC - 1) begin sstep = 1'b1; m_sc = 0; end
      else m_sc = m_sc + 1;
`endif
      if (kstep || sstep) m_s = (m_s + (dir ? 3 : 1)) % 4;
      m_chg = kstep || sstep;
    end
    m_valid = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (s_changed === 1'b1) begin
      change_cnt = change_cnt + 1;
      last_change = cyc;
      chg_t.push_back(cyc);
      chg_v.push_back(int'(s));
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks = n_checks + 1;
      if (s !== 2'(m_s) || s_onehot !== 4'(1 << m_s) || s_changed !== m_chg) begin
        n_fail = n_fail + 1;
        $display("FAIL outputs cyc=%0d: s=%0d onehot=%b chg=%b, required s=%0d onehot=%b chg=%b",
                 cyc, s, s_onehot, s_changed, m_s, 4'(1 << m_s), m_chg);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic d);
    dir = d;
    key_n = 1'b0;
    tick(10);
    key_n = 1'b1;
    tick(10);
  endtask

  initial begin
    int t0;
    int c0;
    logic pat [7];
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // reset
    rst = 1'b1;
    tick(3);
    chk("reset_s", int'(s), 0);
    chk("reset_onehot", int'(s_onehot), 1);
    chk("reset_changed", int'(s_changed), 0);
    rst = 1'b0;
    tick(2);

    // clean press
    dir = 1'b0;
    c0 = change_cnt;
    key_n = 1'b0;
    t0 = cyc;
    tick(20);
    chk("press_pulses", change_cnt - c0, 1);
    chk("press_latency", last_change - t0, 6);
    chk("press_s", int'(s), 1);
    chk("press_onehot", int'(s_onehot), 2);
    key_n = 1'b1;
    tick(10);

    // bounce
    c0 = change_cnt;
    foreach (pat[i]) begin
      key_n = pat[i];
      tick(1);
    end
    key_n = 1'b0;
    t0 = cyc;
    chk("bounce_no_step", change_cnt - c0, 0);
    tick(15);
    chk("bounce_pulses", change_cnt - c0, 1);
    chk("bounce_latency", last_change - t0, 6);
    chk("bounce_s", int'(s), 2);
    key_n = 1'b1;
    tick(10);

    // wrap both ways
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    press(1'b1);
    chk("wrap_down_s", int'(s), 3);
    chk("wrap_down_onehot", int'(s_onehot), 8);
    press(1'b0);
    chk("wrap_up_s", int'(s), 0);

    // reset mid-debounce
    dir = 1'b0;
    c0 = change_cnt;
    key_n = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("middeb_no_step", change_cnt - c0, 0);
    rst = 1'b0;
    t0 = cyc;
    tick(12);
    chk("middeb_pulses", change_cnt - c0, 1);
    chk("middeb_latency", last_change - t0, 6);
    chk("middeb_s", int'(s), 1);
    key_n = 1'b1;
    tick(10);

`ifdef SEL_AUTOSCAN_EN
    // auto-scan
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chg_t.delete();
    chg_v.delete();
    auto_en = 1'b1;
    t0 = cyc;
    tick(45);
    chk("scan_count", chg_t.size(), 4);
    for (int i = 0; i < 4 && i < chg_t.size(); i++) begin
      chk("scan_time", chg_t[i] - t0, 10 * (i + 1));
      chk("scan_value", chg_v[i], (i + 1) % 4);
    end
    auto_en = 1'b0;
    tick(2);

    // key step coinciding with a scan step
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    auto_en = 1'b1;
    t0 = cyc;
    tick(4);
    chg_t.delete();
    chg_v.delete();
    key_n = 1'b0;
    tick(22);
    chk("coinc_count", chg_t.size(), 2);
    if (chg_t.size() >= 2) begin
      chk("coinc_time0", chg_t[0] - t0, 10);
      chk("coinc_value0", chg_v[0], 1);
      chk("coinc_time1", chg_t[1] - t0, 20);
      chk("coinc_value1", chg_v[1], 2);
    end
    key_n = 1'b1;
    auto_en = 1'b0;
    tick(10);
`endif

    // randomized traffic against the model
    repeat (300) begin
      key_n = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
`ifdef SEL_AUTOSCAN_EN
      auto_en = ($urandom_range(0, 3) != 0);
`endif
      rst = ($urandom_range(0, 60) == 0);
      tick(int'($urandom_range(1, 10)));
    end
    rst = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
